// File: rtl/multi_channel_fast_fifo.sv
// multi_channel_fast_fifo
// A bank of CHANNELS single-clock FIFOs sharing one simple dual-port memory.
// Each channel owns a 2^DEPTH_LOG2-word slice addressed as {channel, ptr}.
// One write per cycle goes to a selected channel. One read per cycle is issued by a
// round-robin arbiter over the non-empty channels. Each read word is tagged with
// the channel it came from and appears READ_LATENCY cycles after its grant.
module multi_channel_fast_fifo #(
    parameter int WIDTH              = 32,
    parameter int DEPTH_LOG2         = 5,
    parameter int CHANNELS           = 4,
    parameter int ALMOST_FULL_MARGIN = 8,
    parameter int READ_LATENCY       = 2,
    parameter int FORCE_TO_ZERO      = 0,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                writeEnable,
    input  logic [CH_W-1:0]     writeChannel,
    input  logic [WIDTH-1:0]    dataIn,
    output logic [CHANNELS-1:0] almostFulls,
    output logic [CHANNELS-1:0] overflows,
    input  logic                clearOverflows,
    input  logic                readStall,
    output logic [CHANNELS-1:0] emptys,
    output logic [WIDTH-1:0]    dataOut,
    output logic [CH_W-1:0]     dataOutChannel,
    output logic                dataOutValid
);

    localparam int AW = CH_W + DEPTH_LOG2;
    // Occupancy of a completely full slice; the extra pointer bit makes it distinct from empty.
    localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [2**AW];
    logic [DEPTH_LOG2:0]   wrPtr [CHANNELS];
    logic [DEPTH_LOG2:0]   rdPtr [CHANNELS];
    logic [DEPTH_LOG2:0]   used  [CHANNELS];
    logic [CHANNELS-1:0]   fulls;
    logic [CHANNELS-1:0]   nearFull;
    logic [CHANNELS-1:0]   wrSel;
    logic [CH_W-1:0]       rrPtr;

    logic                  wrReq;
    logic                  wrFull;
    logic [DEPTH_LOG2-1:0] wrLow;
    logic [DEPTH_LOG2-1:0] rdLow;

    logic                  hiFound;
    logic                  loFound;
    logic [CH_W-1:0]       hiCh;
    logic [CH_W-1:0]       loCh;
    logic                  grantValid;
    logic [CH_W-1:0]       grantCh;

    logic [AW-1:0]           rdAddr_p0;
    logic [READ_LATENCY-1:0] vld_p;
    logic [CH_W-1:0]         ch_p [READ_LATENCY];
    logic [WIDTH-1:0]        memQ;
    logic [WIDTH-1:0]        stageData;
    logic [WIDTH-1:0]        lastWord;
    logic [CH_W-1:0]         lastCh;

    // Per-channel occupancy, flags and write-select decode (out-of-range channels select nothing).
    always_comb begin
        used     = '{default: '0};
        emptys   = '0;
        fulls    = '0;
        nearFull = '0;
        wrSel    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            used[c]     = wrPtr[c] - rdPtr[c];
            emptys[c]   = (used[c] == '0);
            fulls[c]    = (used[c] == CAPACITY);
            nearFull[c] = (32'(CAPACITY - used[c]) <= ALMOST_FULL_MARGIN);
            wrSel[c]    = writeEnable && (writeChannel == CH_W'(c));
        end
    end

    // Select the write slot and full flag of the addressed channel.
    always_comb begin
        wrLow  = '0;
        wrFull = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wrSel[c]) begin
                wrLow  = wrPtr[c][DEPTH_LOG2-1:0];
                wrFull = fulls[c];
            end
        end
        wrReq = |wrSel;
    end

    // Round-robin: lowest non-empty channel at or above rrPtr, else lowest non-empty overall.
    always_comb begin
        hiFound = 1'b0;
        hiCh    = '0;
        loFound = 1'b0;
        loCh    = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (!emptys[c]) begin
                loFound = 1'b1;
                loCh    = CH_W'(c);
                if (c >= int'(rrPtr)) begin
                    hiFound = 1'b1;
                    hiCh    = CH_W'(c);
                end
            end
        end
        grantValid = loFound && !readStall;
        grantCh    = hiFound ? hiCh : loCh;
    end

    // Read slot of the granted channel.
    always_comb begin
        rdLow = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grantCh == CH_W'(c)) rdLow = rdPtr[c][DEPTH_LOG2-1:0];
        end
    end

    // Pointers, arbiter state, registered almost-full and sticky overflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wrPtr[c] <= '0;
                rdPtr[c] <= '0;
            end
            rrPtr       <= '0;
            almostFulls <= '0;
            overflows   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wrSel[c] && !fulls[c]) wrPtr[c] <= wrPtr[c] + 1'b1;
                if (grantValid && (grantCh == CH_W'(c))) rdPtr[c] <= rdPtr[c] + 1'b1;
                // A full channel drops the word even when it is read this same cycle.
                overflows[c] <= !clearOverflows && (overflows[c] || (wrSel[c] && fulls[c]));
            end
            almostFulls <= nearFull;
            if (grantValid) rrPtr <= (32'(grantCh) == CHANNELS - 1) ? '0 : grantCh + 1'b1;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wrReq && !wrFull) mem[{writeChannel, wrLow}] <= dataIn;
    end

    // Stage p0: register the read address of this cycle's grant.
    always_ff @(posedge clk) begin
        rdAddr_p0 <= {grantCh, rdLow};
    end

    assign memQ = mem[rdAddr_p0];

    // Grant flag pipeline; cleared by reset so an in-flight read never surfaces.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= grantValid;
            for (int k = 1; k < READ_LATENCY; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    // Channel tag pipeline travelling beside the grant flag.
    always_ff @(posedge clk) begin
        ch_p[0] <= grantCh;
        for (int k = 1; k < READ_LATENCY; k++) ch_p[k] <= ch_p[k-1];
    end

    generate
        if (READ_LATENCY == 1) begin : gDirect
            assign stageData = memQ;
        end else begin : gDelay
            logic [WIDTH-1:0] data_p [READ_LATENCY-1];
            // Stages p1..: delay the memory word so it lines up with the grant flag.
            always_ff @(posedge clk) begin
                data_p[0] <= memQ;
                for (int k = 1; k < READ_LATENCY - 1; k++) data_p[k] <= data_p[k-1];
            end
            assign stageData = data_p[READ_LATENCY-2];
        end
    endgenerate

    // Remember the last delivered word and tag so the outputs can hold between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastWord <= '0;
            lastCh   <= '0;
        end else if (vld_p[READ_LATENCY-1]) begin
            lastWord <= stageData;
            lastCh   <= ch_p[READ_LATENCY-1];
        end
    end

    assign dataOutValid   = vld_p[READ_LATENCY-1];
    assign dataOutChannel = dataOutValid ? ch_p[READ_LATENCY-1] : lastCh;
    assign dataOut        = dataOutValid ? stageData
                                         : ((FORCE_TO_ZERO != 0) ? '0 : lastWord);

endmodule

// File: tb/tb_multi_channel_fast_fifo.sv
// Testbench for multi_channel_fast_fifo: a hand-derived vector table, directed corner
// sequences and random traffic checked against a queue-based reference model.
// A second instance with FORCE_TO_ZERO=1 runs on the same inputs.
module tb_multi_channel_fast_fifo;

    localparam int WIDTH      = 32;
    localparam int DEPTH_LOG2 = 5;
    localparam int CHANNELS   = 4;
    localparam int MARGIN     = 8;
    localparam int LAT        = 2;
    localparam int CAP        = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        writeEnable = 1'b0;
    logic [1:0]  writeChannel = '0;
    logic [31:0] dataIn = '0;
    logic        clearOverflows = 1'b0;
    logic        readStall = 1'b0;

    logic [3:0]  almostFulls, overflows, emptys;
    logic [31:0] dataOut;
    logic [1:0]  dataOutChannel;
    logic        dataOutValid;

    logic [3:0]  almostFullsZ, overflowsZ, emptysZ;
    logic [31:0] dataOutZ;
    logic [1:0]  dataOutChannelZ;
    logic        dataOutValidZ;

    multi_channel_fast_fifo #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .CHANNELS(CHANNELS),
        .ALMOST_FULL_MARGIN(MARGIN), .READ_LATENCY(LAT), .FORCE_TO_ZERO(0)
    ) dut (
        .clk(clk), .rst(rst), .writeEnable(writeEnable), .writeChannel(writeChannel),
        .dataIn(dataIn), .almostFulls(almostFulls), .overflows(overflows),
        .clearOverflows(clearOverflows), .readStall(readStall), .emptys(emptys),
        .dataOut(dataOut), .dataOutChannel(dataOutChannel), .dataOutValid(dataOutValid)
    );

    multi_channel_fast_fifo #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .CHANNELS(CHANNELS),
        .ALMOST_FULL_MARGIN(MARGIN), .READ_LATENCY(LAT), .FORCE_TO_ZERO(1)
    ) dutZero (
        .clk(clk), .rst(rst), .writeEnable(writeEnable), .writeChannel(writeChannel),
        .dataIn(dataIn), .almostFulls(almostFullsZ), .overflows(overflowsZ),
        .clearOverflows(clearOverflows), .readStall(readStall), .emptys(emptysZ),
        .dataOut(dataOutZ), .dataOutChannel(dataOutChannelZ), .dataOutValid(dataOutValidZ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    // Reference model state: one queue of stored words per channel.
    logic [31:0] q [CHANNELS][$];
    int          rr;
    logic [3:0]  afM, ovM;
    logic [31:0] lastW;
    logic [1:0]  lastC;
    logic [31:0] pendD [int];
    logic [1:0]  pendC [int];

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic [31:0] din;
        logic        st;
        logic        expV;
        logic [1:0]  expCh;
        logic [31:0] expD;
        logic [3:0]  expE;
    } vec_t;
    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic setIn(input logic we, input logic [1:0] ch, input logic [31:0] d,
                         input logic st, input logic cl);
        writeEnable    = we;
        writeChannel   = ch;
        dataIn         = d;
        readStall      = st;
        clearOverflows = cl;
    endtask

    task automatic modelReset();
        for (int c = 0; c < CHANNELS; c++) q[c].delete();
        pendD.delete();
        pendC.delete();
        rr    = 0;
        afM   = '0;
        ovM   = '0;
        lastW = '0;
        lastC = '0;
    endtask

    // Compare both DUTs against the model state reached after the last clock edge.
    task automatic modelCheck();
        logic [3:0] expE;
        for (int c = 0; c < CHANNELS; c++) expE[c] = (q[c].size() == 0);
        chk("emptys", 32'(emptys), 32'(expE));
        chk("emptys_z", 32'(emptysZ), 32'(expE));
        chk("almostFulls", 32'(almostFulls), 32'(afM));
        chk("almostFulls_z", 32'(almostFullsZ), 32'(afM));
        chk("overflows", 32'(overflows), 32'(ovM));
        chk("overflows_z", 32'(overflowsZ), 32'(ovM));
        if (pendD.exists(cyc)) begin
            chk("valid", 32'(dataOutValid), 32'd1);
            chk("data", dataOut, pendD[cyc]);
            chk("chan", 32'(dataOutChannel), 32'(pendC[cyc]));
            chk("valid_z", 32'(dataOutValidZ), 32'd1);
            chk("data_z", dataOutZ, pendD[cyc]);
            chk("chan_z", 32'(dataOutChannelZ), 32'(pendC[cyc]));
            lastW = pendD[cyc];
            lastC = pendC[cyc];
            pendD.delete(cyc);
            pendC.delete(cyc);
        end else begin
            chk("valid_idle", 32'(dataOutValid), 32'd0);
            chk("data_hold", dataOut, lastW);
            chk("chan_hold", 32'(dataOutChannel), 32'(lastC));
            chk("valid_idle_z", 32'(dataOutValidZ), 32'd0);
            chk("data_zero_z", dataOutZ, 32'd0);
        end
    endtask

    // Apply one cycle of the FIFO rules to the model using the inputs now driven.
    task automatic modelAdvance();
        int         sz [CHANNELS];
        logic [3:0] setOv;
        bit         found;
        int         g;
        logic [31:0] w;
        for (int c = 0; c < CHANNELS; c++) sz[c] = q[c].size();
        found = 0;
        g     = 0;
        if (!readStall) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!found && sz[(rr + i) % CHANNELS] > 0) begin
                    found = 1;
                    g     = (rr + i) % CHANNELS;
                end
            end
        end
        if (found) begin
            w = q[g].pop_front();
            pendD[cyc + LAT] = w;
            pendC[cyc + LAT] = 2'(g);
            rr = (g + 1) % CHANNELS;
        end
        setOv = '0;
        if (writeEnable) begin
            if (sz[writeChannel] == CAP) setOv[writeChannel] = 1'b1;
            else q[writeChannel].push_back(dataIn);
        end
        for (int c = 0; c < CHANNELS; c++) afM[c] = ((CAP - sz[c]) <= MARGIN);
        ovM = clearOverflows ? 4'b0000 : (ovM | setOv);
    endtask

    task automatic step();
        modelCheck();
        modelAdvance();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted at the current point, held over two edges.
    task automatic applyReset();
        setIn(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        modelReset();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_valid", 32'(dataOutValid), 32'd0);
            chk("rst_emptys", 32'(emptys), 32'hF);
            chk("rst_overflows", 32'(overflows), 32'h0);
            chk("rst_dataOut", dataOut, 32'h0);
        end
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin order from rrPtr=0, then a single ch1 word, then three ch2 words.
        //            we    ch     din       st    expV  expCh  expD      expE
        vecs[0]  = '{1'b1, 2'd0, 32'hB0, 1'b1, 1'b0, 2'd0, 32'h00, 4'b1111};
        vecs[1]  = '{1'b1, 2'd1, 32'hB1, 1'b1, 1'b0, 2'd0, 32'h00, 4'b1110};
        vecs[2]  = '{1'b1, 2'd2, 32'hB2, 1'b1, 1'b0, 2'd0, 32'h00, 4'b1100};
        vecs[3]  = '{1'b1, 2'd3, 32'hB3, 1'b1, 1'b0, 2'd0, 32'h00, 4'b1000};
        vecs[4]  = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b0, 2'd0, 32'h00, 4'b0000};
        vecs[5]  = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b0, 2'd0, 32'h00, 4'b0001};
        vecs[6]  = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 2'd0, 32'hB0, 4'b0011};
        vecs[7]  = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 2'd1, 32'hB1, 4'b0111};
        vecs[8]  = '{1'b1, 2'd1, 32'hC1, 1'b0, 1'b1, 2'd2, 32'hB2, 4'b1111};
        vecs[9]  = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 2'd3, 32'hB3, 4'b1101};
        vecs[10] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b0, 2'd3, 32'hB3, 4'b1111};
        vecs[11] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 2'd1, 32'hC1, 4'b1111};
        vecs[12] = '{1'b1, 2'd2, 32'hA0, 1'b0, 1'b0, 2'd1, 32'hC1, 4'b1111};
        vecs[13] = '{1'b1, 2'd2, 32'hA1, 1'b0, 1'b0, 2'd1, 32'hC1, 4'b1011};
        vecs[14] = '{1'b1, 2'd2, 32'hA2, 1'b0, 1'b0, 2'd1, 32'hC1, 4'b1011};
        vecs[15] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2, 32'hA0, 4'b1011};
        vecs[16] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2, 32'hA1, 4'b1111};
        vecs[17] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b1, 2'd2, 32'hA2, 4'b1111};
        vecs[18] = '{1'b0, 2'd0, 32'h00, 1'b0, 1'b0, 2'd2, 32'hA2, 4'b1111};

        setIn(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        applyReset();

        // Vector table.
        for (int r = 0; r < 19; r++) begin
            chk($sformatf("tbl%0d_valid", r), 32'(dataOutValid), 32'(vecs[r].expV));
            chk($sformatf("tbl%0d_chan", r), 32'(dataOutChannel), 32'(vecs[r].expCh));
            chk($sformatf("tbl%0d_data", r), dataOut, vecs[r].expD);
            chk($sformatf("tbl%0d_emptys", r), 32'(emptys), 32'(vecs[r].expE));
            setIn(vecs[r].we, vecs[r].ch, vecs[r].din, vecs[r].st, 1'b0);
            step();
        end

        // Reset while reads are in flight.
        for (int i = 0; i < 4; i++) begin
            setIn(1'b1, 2'd0, 32'h100 + i, 1'b1, 1'b0);
            step();
        end
        setIn(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            setIn(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
            chk("t1_valid_after", 32'(dataOutValid), 32'd0);
            chk("t1_emptys_after", 32'(emptys), 32'hF);
            chk("t1_ovf_after", 32'(overflows), 32'h0);
            step();
        end

        // Fill ch1, almost-full timing, overflow and clear priority.
        for (int k = 0; k < 32; k++) begin
            setIn(1'b1, 2'd1, 32'h400 + k, 1'b1, 1'b0);
            if (k == 24) chk("t4_af_used24_same_cycle", 32'(almostFulls[1]), 32'd0);
            if (k == 25) chk("t4_af_cycle_after_24", 32'(almostFulls[1]), 32'd1);
            step();
        end
        setIn(1'b1, 2'd1, 32'h4FF, 1'b1, 1'b0);
        step();
        chk("t4_ovf_set", 32'(overflows[1]), 32'd1);
        setIn(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        chk("t4_ovf_sticky", 32'(overflows[1]), 32'd1);
        setIn(1'b1, 2'd1, 32'h4FE, 1'b1, 1'b1);
        step();
        chk("t4_clear_wins", 32'(overflows[1]), 32'd0);
        setIn(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        repeat (36) step();

        // Full ch0 streaming through pointer wrap.
        applyReset();
        for (int k = 0; k < 32; k++) begin
            setIn(1'b1, 2'd0, 32'h500 + k, 1'b1, 1'b0);
            step();
        end
        setIn(1'b1, 2'd0, 32'h5FF, 1'b0, 1'b0);
        step();
        chk("t5_drop_when_full_and_granted", 32'(overflows[0]), 32'd1);
        for (int k = 0; k < 100; k++) begin
            setIn(1'b1, 2'd0, 32'h600 + k, 1'b0, (k == 0) ? 1'b1 : 1'b0);
            step();
        end
        chk("t5_no_overflow", 32'(overflows[0]), 32'd0);
        chk("t5_not_empty", 32'(emptys[0]), 32'd0);
        chk("t5_almost_full", 32'(almostFulls[0]), 32'd1);
        setIn(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        repeat (40) step();

        // Random traffic: light then heavy read stalling.
        for (int n = 0; n < 600; n++) begin
            setIn($urandom_range(0, 99) < 65, 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 99) < ((n < 300) ? 20 : 75),
                  $urandom_range(0, 99) < 4);
            step();
        end
        setIn(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        repeat (140) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
